// File: rtl/pwm_clkgen.sv
// Multi-channel clock/PWM generator: shadowed per-channel config applied at period boundaries.
// Define PWM_CLKGEN_PHASE_EN to build the start-phase offset (PHASE state and phase storage).
module pwm_clkgen #(
  parameter int unsigned CH  = 4,
  parameter int unsigned CW  = 16,
  localparam int unsigned ChW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [ChW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic [CW-1:0]  cfg_ton,
  input  logic [CW-1:0]  cfg_phase,
  input  logic [CH-1:0]  en,
  output logic [CH-1:0]  clk_out,
  output logic [CH-1:0]  sync_pulse
);

  typedef enum logic [1:0] {StIdle, StPhase, StRun} state_e;

  state_e        state_q   [CH];
  state_e        state_d   [CH];
  logic [CW-1:0] cnt_q     [CH];
  logic [CW-1:0] cnt_d     [CH];
  logic [CW-1:0] sh_per_q  [CH];
  logic [CW-1:0] sh_per_d  [CH];
  logic [CW-1:0] sh_ton_q  [CH];
  logic [CW-1:0] sh_ton_d  [CH];
  logic [CW-1:0] act_per_q [CH];
  logic [CW-1:0] act_per_d [CH];
  logic [CW-1:0] act_ton_q [CH];
  logic [CW-1:0] act_ton_d [CH];
`ifdef PWM_CLKGEN_PHASE_EN
  logic [CW-1:0] sh_ph_q   [CH];
  logic [CW-1:0] sh_ph_d   [CH];
  logic [CW-1:0] act_ph_q  [CH];
  logic [CW-1:0] act_ph_d  [CH];
`else
  logic          unused_phase;
  assign unused_phase = ^cfg_phase;
`endif

  logic [CH-1:0] pending_q, pending_d;
  logic [CH-1:0] clk_out_q, clk_out_d;
  logic [CH-1:0] sync_q, sync_d;
  logic [CH-1:0] wr;

  // Out-of-range channel numbers match nothing: ready stays high and the write is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    wr        = '0;
    for (int i = 0; i < CH; i++) begin
      if (cfg_ch == ChW'(i)) begin
        cfg_ready = ~pending_q[i];
        wr[i]     = cfg_valid & ~pending_q[i];
      end
    end
  end

  always_comb begin
    logic          apply;
    logic [CW-1:0] start_per;
`ifdef PWM_CLKGEN_PHASE_EN
    logic [CW-1:0] start_ph;
    start_ph  = '0;
`endif
    apply     = 1'b0;
    start_per = '0;
    for (int i = 0; i < CH; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      pending_d[i] = pending_q[i];
      sh_per_d[i]  = sh_per_q[i];
      sh_ton_d[i]  = sh_ton_q[i];
      act_per_d[i] = act_per_q[i];
      act_ton_d[i] = act_ton_q[i];
`ifdef PWM_CLKGEN_PHASE_EN
      sh_ph_d[i]   = sh_ph_q[i];
      act_ph_d[i]  = act_ph_q[i];
`endif
      apply        = 1'b0;

      // A write is only possible with pending clear, so it never collides with apply.
      if (wr[i]) begin
        sh_per_d[i]  = cfg_period;
        sh_ton_d[i]  = cfg_ton;
`ifdef PWM_CLKGEN_PHASE_EN
        sh_ph_d[i]   = cfg_phase;
`endif
        pending_d[i] = 1'b1;
      end

      unique case (state_q[i])
        StIdle: begin
          start_per = pending_q[i] ? sh_per_q[i] : act_per_q[i];
`ifdef PWM_CLKGEN_PHASE_EN
          start_ph  = pending_q[i] ? sh_ph_q[i] : act_ph_q[i];
`endif
          if (en[i] && (start_per != '0)) begin
            apply      = pending_q[i];
            cnt_d[i]   = '0;
            state_d[i] = StRun;
`ifdef PWM_CLKGEN_PHASE_EN
            if (start_ph != '0) state_d[i] = StPhase;
`endif
          end
        end
`ifdef PWM_CLKGEN_PHASE_EN
        StPhase: begin
          if (!en[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == act_ph_q[i] - CW'(1)) begin
            cnt_d[i]   = '0;
            state_d[i] = StRun;
          end else begin
            cnt_d[i]   = cnt_q[i] + CW'(1);
          end
        end
`endif
        StRun: begin
          if (cnt_q[i] == act_per_q[i] - CW'(1)) begin
            cnt_d[i] = '0;
            if (!en[i]) begin
              state_d[i] = StIdle;
            end else if (pending_q[i]) begin
              apply = 1'b1;
              // A zero period cannot run; park in idle with the new config active.
              if (sh_per_q[i] == '0) state_d[i] = StIdle;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase

      if (apply) begin
        act_per_d[i] = sh_per_q[i];
        act_ton_d[i] = sh_ton_q[i];
`ifdef PWM_CLKGEN_PHASE_EN
        act_ph_d[i]  = sh_ph_q[i];
`endif
        pending_d[i] = 1'b0;
      end

      // Outputs are registered from next state so they line up with the counter value.
      clk_out_d[i] = (state_d[i] == StRun) && (cnt_d[i] < act_ton_d[i]);
      sync_d[i]    = (state_d[i] == StRun) && (cnt_d[i] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i]   <= StIdle;
        cnt_q[i]     <= '0;
        sh_per_q[i]  <= '0;
        sh_ton_q[i]  <= '0;
        act_per_q[i] <= '0;
        act_ton_q[i] <= '0;
`ifdef PWM_CLKGEN_PHASE_EN
        sh_ph_q[i]   <= '0;
        act_ph_q[i]  <= '0;
`endif
      end
      pending_q <= '0;
      clk_out_q <= '0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_per_q  <= sh_per_d;
      sh_ton_q  <= sh_ton_d;
      act_per_q <= act_per_d;
      act_ton_q <= act_ton_d;
`ifdef PWM_CLKGEN_PHASE_EN
      sh_ph_q   <= sh_ph_d;
      act_ph_q  <= act_ph_d;
`endif
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      sync_q    <= sync_d;
    end
  end

  assign clk_out    = clk_out_q;
  assign sync_pulse = sync_q;

endmodule

// File: tb/tb_pwm_clkgen.sv
// Scoreboard bench for pwm_clkgen: the driver pushes per-cycle expectations, a negedge
// monitor pops and compares them against clk_out, sync_pulse and cfg_ready.
module tb_pwm_clkgen;
  localparam int unsigned CH = 4;
  localparam int unsigned CW = 16;
`ifdef PWM_CLKGEN_PHASE_EN
  localparam int PhEn = 1;
`else
  localparam int PhEn = 0;
`endif
  localparam int Never = 32'h3fff_ffff;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_ch = '0;
  logic [CW-1:0] cfg_period = '0;
  logic [CW-1:0] cfg_ton = '0;
  logic [CW-1:0] cfg_phase = '0;
  logic [CH-1:0] en = '0;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] sync_pulse;

  pwm_clkgen #(.CH(CH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_ton    (cfg_ton),
    .cfg_phase  (cfg_phase),
    .en         (en),
    .clk_out    (clk_out),
    .sync_pulse (sync_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] clk_o;
    logic [CH-1:0] sync;
    bit            chk_rdy;
    logic          rdy;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc_n   = 0;

  // Reference waveform per channel: start edge, period, ton, phase, first silent cycle.
  int m_on [CH];
  int m_t0 [CH];
  int m_per[CH];
  int m_ton[CH];
  int m_ph [CH];
  int m_end[CH];

  task automatic check(input string nm, input int cyc, input logic [CH-1:0] act,
                       input logic [CH-1:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, want);
  endtask

  function automatic void model(input int c, output logic [CH-1:0] eo, output logic [CH-1:0] es);
    eo = '0;
    es = '0;
    for (int ch = 0; ch < CH; ch++) begin
      int k;
      int j;
      k = c - m_t0[ch];
      if (m_on[ch] != 0 && k >= m_ph[ch] && c < m_end[ch]) begin
        j = (k - m_ph[ch]) % m_per[ch];
        eo[ch] = (j < m_ton[ch]);
        es[ch] = (j == 0);
      end
    end
  endfunction

  // First cycle with outputs low after en drops (sampled low from cycle c onward).
  function automatic int end_at(input int ch, input int c);
    int n;
    n = c - m_t0[ch] - m_ph[ch];
    return m_t0[ch] + m_ph[ch] + ((n + m_per[ch] - 1) / m_per[ch]) * m_per[ch];
  endfunction

  task automatic start(input int ch, input int per, input int ton, input int ph);
    m_on[ch]  = 1;
    m_t0[ch]  = cyc_n;
    m_per[ch] = per;
    m_ton[ch] = ton;
    m_ph[ch]  = ph;
    m_end[ch] = Never;
  endtask

  task automatic tick(input bit chk_rdy = 1'b0, input logic rdy = 1'b1);
    exp_t          e;
    logic [CH-1:0] eo;
    logic [CH-1:0] es;
    model(cyc_n, eo, es);
    e.clk_o   = eo;
    e.sync    = es;
    e.chk_rdy = chk_rdy;
    e.rdy     = rdy;
    e.cyc     = cyc_n;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic cfg_wr(input int ch, input int per, input int ton, input int ph);
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = CW'(per);
    cfg_ton    = CW'(ton);
    cfg_phase  = CW'(ph);
    tick(1'b1, 1'b0);
    cfg_valid  = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("clk_out", e.cyc, clk_out, e.clk_o);
      check("sync_pulse", e.cyc, sync_pulse, e.sync);
      if (e.chk_rdy)
        check("cfg_ready", e.cyc, {{(CH-1){1'b0}}, cfg_ready}, {{(CH-1){1'b0}}, e.rdy});
    end
  end

  initial begin
    for (int ch = 0; ch < CH; ch++) begin
      m_on[ch]  = 0;
      m_t0[ch]  = 0;
      m_per[ch] = 1;
      m_ton[ch] = 0;
      m_ph[ch]  = 0;
      m_end[ch] = Never;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_clk_out", cyc_n, clk_out, '0);
    check("rst_sync", cyc_n, sync_pulse, '0);
    check("rst_ready", cyc_n, {{(CH-1){1'b0}}, cfg_ready}, {{(CH-1){1'b0}}, 1'b1});
    rst = 1'b0;
    repeat (3) tick(1'b1, 1'b1);

    // ch0 10/5 no phase, ch1 4/1 phase 3, running together.
    cfg_wr(0, 10, 5, 0);
    cfg_wr(1, 4, 1, 3);
    en = 4'b0011;
    start(0, 10, 5, 0);
    start(1, 4, 1, (PhEn != 0) ? 3 : 0);
    tick(1'b1, 1'b1);
    ticks(29);
    m_end[0] = end_at(0, cyc_n);
    m_end[1] = end_at(1, cyc_n);
    en = 4'b0000;
    ticks(12);

    // Edge values: ch1 period 0 never starts, ch2 ton 0, ch3 ton above period.
    cfg_wr(1, 0, 5, 0);
    cfg_wr(2, 8, 0, 0);
    cfg_wr(3, 10, 12, 0);
    m_on[1] = 0;
    en = 4'b1110;
    start(2, 8, 0, 0);
    start(3, 10, 12, 0);
    cfg_ch = 2'd1;
    tick(1'b1, 1'b0);
    ticks(19);
    m_end[2] = end_at(2, cyc_n);
    m_end[3] = end_at(3, cyc_n);
    en = 4'b0000;
    ticks(12);

    // Reconfigure ch0 while running; a second write in the pending window must stall.
    en = 4'b0001;
    start(0, 10, 5, 0);
    cfg_ch = 2'd0;
    tick(1'b1, 1'b1);
    repeat (3) tick(1'b1, 1'b1);
    cfg_valid  = 1'b1;
    cfg_period = CW'(6);
    cfg_ton    = CW'(2);
    cfg_phase  = '0;
    tick(1'b1, 1'b0);
    cfg_period = CW'(7);
    cfg_ton    = CW'(7);
    repeat (4) tick(1'b1, 1'b0);
    cfg_valid = 1'b0;
    tick(1'b1, 1'b0);
    start(0, 6, 2, 0);
    tick(1'b1, 1'b1);
    ticks(13);
    m_end[0] = end_at(0, cyc_n);
    en = 4'b0000;
    ticks(8);

    // Idle write takes effect at the next start; en drop mid-period completes the period.
    cfg_wr(0, 10, 5, 0);
    en = 4'b0001;
    start(0, 10, 5, 0);
    tick(1'b1, 1'b1);
    ticks(2);
    m_end[0] = end_at(0, cyc_n);
    en = 4'b0000;
    ticks(12);

    // en dropped then re-raised before the boundary: no gap.
    en = 4'b0001;
    start(0, 10, 5, 0);
    ticks(3);
    en = 4'b0000;
    ticks(4);
    en = 4'b0001;
    ticks(16);

    // Asynchronous reset in the middle of a high phase, with ch1 still pending.
    cfg_ch = 2'd1;
    #1;
    check("pre_rst_clk_out", cyc_n, clk_out, 4'b0001);
    check("pre_rst_ready", cyc_n, {{(CH-1){1'b0}}, cfg_ready}, '0);
    rst = 1'b1;
    #1;
    check("async_rst_clk_out", cyc_n, clk_out, '0);
    check("async_rst_sync", cyc_n, sync_pulse, '0);
    check("async_rst_ready", cyc_n, {{(CH-1){1'b0}}, cfg_ready}, {{(CH-1){1'b0}}, 1'b1});
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    for (int ch = 0; ch < CH; ch++) m_on[ch] = 0;

    // All-zero config after reset: enable must not start anything.
    en = 4'b1111;
    cfg_ch = 2'd0;
    tick(1'b1, 1'b1);
    ticks(5);
    en = 4'b0000;

    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
